// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target: register indices, STATUS/CTRL bit
// positions, the FILL reset byte and the STATUS word layout.
package spi_target_pkg;
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_FILL   = 2'd3;

   localparam int ST_RXNE   = 0;
   localparam int ST_RXFULL = 1;
   localparam int ST_TXFULL = 2;
   localparam int ST_CSACT  = 3;
   localparam int ST_UNDER  = 4;
   localparam int ST_OVER   = 5;
   localparam int ST_EOF    = 6;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_RXIE  = 1;
   localparam int CTRL_EOFIE = 2;

   localparam logic [7:0] FILL_RST = 8'hFF;

   // Field order matches STATUS bits 6..0.
   typedef struct packed {
      logic eof;
      logic overrun;
      logic underrun;
      logic cs_active;
      logic tx_full;
      logic rx_full;
      logic rx_nonempty;
   } status_t;

   function automatic logic [31:0] pack_status(status_t s);
      return {25'b0, s};
   endfunction
endpackage

// File: rtl/spi_target_if.sv
// CPU-side register bus of the SPI target (select/wr/rd/addr decode).
interface spi_target_if;
   logic        select;
   logic [3:0]  wr;
   logic        rd;
   logic [1:0]  addr;
   logic [31:0] data_in;
   logic [31:0] data_out;

   modport master (output select, wr, rd, addr, data_in, input data_out);
   modport slave  (input select, wr, rd, addr, data_in, output data_out);
endinterface

// File: rtl/spi_target_fifo.sv
// Synchronous byte FIFO; pointers carry one extra wrap bit so full and
// empty fall out of a plain pointer comparison.
module spi_target_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_push,
   input  logic [7:0] i_din,
   input  logic       i_pop,
   output logic [7:0] o_head,
   output logic       o_full,
   output logic       o_empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0] r_wp, r_rp;
   logic [7:0]  r_mem [DEPTH];
   logic        w_pop, w_push;

   assign o_empty = (r_wp == r_rp);
   assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign o_head  = r_mem[r_rp[AW-1:0]];
   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wp <= '0;
         r_rp <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wp[AW-1:0]] <= i_din;
            r_wp <= r_wp + (AW+1)'(1);
         end
         if (w_pop) r_rp <= r_rp + (AW+1)'(1);
      end
   end
endmodule

// File: rtl/spi_target.sv
// SPI target (mode 0/3, MSB first) with oversampled pins, RX FIFO,
// one-byte TX holding register and a 4-register CPU window.
module spi_target
   import spi_target_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          reset,
   spi_target_if.slave   bus,
   output logic          interrupt,
   input  logic          spi_sck,
   input  logic          spi_cs_n,
   input  logic          spi_mosi,
   output logic          spi_miso,
   output logic          spi_miso_oe
);
   logic [SYNC_STAGES-1:0] r_sck_s, r_cs_s, r_mosi_s;
   logic       r_sck_d, r_cs_d;
   logic [2:0] r_ctrl, r_cnt;
   logic [7:0] r_fill, r_txhold, r_tx_shift;
   logic [6:0] r_rx_shift;
   logic       r_tx_full, r_eof, r_ovr, r_und;
   logic       r_miso, r_miso_oe, r_pend, r_irq;

   logic       w_sck, w_cs_n, w_mosi, w_en, w_cs_act;
   logic       w_cs_fall, w_cs_rise, w_rise, w_fall, w_last;
   logic       w_pop, w_full, w_empty, w_unused;
   logic       w_data_wr, w_st_wr, w_ctrl_wr, w_fill_wr;
   logic [7:0] w_head, w_byte, w_load_byte;
   status_t    w_status;

   assign w_sck    = r_sck_s[SYNC_STAGES-1];
   assign w_cs_n   = r_cs_s[SYNC_STAGES-1];
   assign w_mosi   = r_mosi_s[SYNC_STAGES-1];
   assign w_en     = r_ctrl[CTRL_EN];
   assign w_cs_act = ~w_cs_n;

   assign w_cs_fall = w_en & ~w_cs_n & r_cs_d;
   assign w_cs_rise = w_en & w_cs_n & ~r_cs_d;
   assign w_rise    = w_en & w_cs_act & w_sck & ~r_sck_d;
   assign w_fall    = w_en & w_cs_act & ~w_sck & r_sck_d;
   assign w_last    = w_rise & (r_cnt == 3'd7);
   assign w_byte    = {r_rx_shift, w_mosi};
   assign w_load_byte = r_tx_full ? r_txhold : r_fill;

   assign w_data_wr = bus.select & bus.wr[0] & (bus.addr == REG_DATA);
   assign w_st_wr   = bus.select & (|bus.wr) & (bus.addr == REG_STATUS);
   assign w_ctrl_wr = bus.select & (|bus.wr) & (bus.addr == REG_CTRL);
   assign w_fill_wr = bus.select & (|bus.wr) & (bus.addr == REG_FILL);
   assign w_pop     = bus.select & bus.rd & (bus.addr == REG_DATA) & ~w_empty;
   assign w_unused  = ^bus.data_in[31:8];

   spi_target_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (clk),
      .i_reset (reset),
      .i_push  (w_last),
      .i_din   (w_byte),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_status = '{eof: r_eof, overrun: r_ovr, underrun: r_und,
                       cs_active: w_cs_act, tx_full: r_tx_full,
                       rx_full: w_full, rx_nonempty: ~w_empty};

   always_comb begin
      bus.data_out = '0;
      case (bus.addr)
         REG_DATA:   bus.data_out = {23'b0, ~w_empty, w_head};
         REG_STATUS: bus.data_out = pack_status(w_status);
         REG_CTRL:   bus.data_out = {29'b0, r_ctrl};
         default:    bus.data_out = {24'b0, r_fill};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sck_s    <= '0;
         r_cs_s     <= '1;
         r_mosi_s   <= '0;
         r_sck_d    <= 1'b0;
         r_cs_d     <= 1'b1;
         r_ctrl     <= '0;
         r_fill     <= FILL_RST;
         r_txhold   <= '0;
         r_tx_full  <= 1'b0;
         r_tx_shift <= '0;
         r_rx_shift <= '0;
         r_cnt      <= '0;
         r_eof      <= 1'b0;
         r_ovr      <= 1'b0;
         r_und      <= 1'b0;
         r_miso     <= 1'b1;
         r_miso_oe  <= 1'b0;
         r_pend     <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         r_sck_s  <= (r_sck_s << 1) | SYNC_STAGES'(spi_sck);
         r_cs_s   <= (r_cs_s << 1) | SYNC_STAGES'(spi_cs_n);
         r_mosi_s <= (r_mosi_s << 1) | SYNC_STAGES'(spi_mosi);
         r_sck_d  <= w_sck;
         r_cs_d   <= w_cs_n;

         if (w_ctrl_wr) r_ctrl <= bus.data_in[2:0];
         if (w_fill_wr) r_fill <= bus.data_in[7:0];

         if (w_cs_fall | w_last) r_tx_full <= 1'b0;
         if (w_data_wr) begin
            r_txhold  <= bus.data_in[7:0];
            r_tx_full <= 1'b1;
         end

         if (!w_en || !w_cs_act) r_cnt <= '0;
         else if (w_rise) begin
            r_rx_shift <= w_byte[6:0];
            r_cnt      <= r_cnt + 3'd1;
         end

         // r_pend: next falling edge presents bit 7 instead of shifting. Set
         // after every reload, and at CS assertion only if SCK idles high.
         if (!w_en || !w_cs_act) begin
            r_miso <= 1'b1;
            r_pend <= 1'b0;
         end else if (w_cs_fall) begin
            r_tx_shift <= w_load_byte;
            r_miso     <= w_load_byte[7];
            r_pend     <= w_sck;
         end else if (w_last) begin
            r_tx_shift <= w_load_byte;
            r_pend     <= 1'b1;
         end else if (w_fall) begin
            if (r_pend) begin
               r_miso <= r_tx_shift[7];
               r_pend <= 1'b0;
            end else begin
               r_tx_shift <= r_tx_shift << 1;
               r_miso     <= r_tx_shift[6];
            end
         end

         // eof marks every end of frame; a same-cycle set beats a W1C clear.
         r_eof <= w_cs_rise | (r_eof & ~(w_st_wr & bus.data_in[ST_EOF]));
         r_ovr <= (w_last & w_full & ~w_pop) | (r_ovr & ~(w_st_wr & bus.data_in[ST_OVER]));
         r_und <= ((w_cs_fall | w_last) & ~r_tx_full) |
                  (r_und & ~(w_st_wr & bus.data_in[ST_UNDER]));

         r_miso_oe <= w_cs_act & w_en;
         r_irq     <= (r_ctrl[CTRL_RXIE] & ~w_empty) | (r_ctrl[CTRL_EOFIE] & r_eof);
      end
   end

   assign spi_miso    = r_miso;
   assign spi_miso_oe = r_miso_oe;
   assign interrupt   = r_irq;
endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a bit-banged SPI host plus CPU register
// accesses, each scenario checking against hand-derived values.
module tb_spi_target;
   import spi_target_pkg::*;

   localparam int HALF = 6;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic interrupt, spi_miso, spi_miso_oe;
   logic spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
   bit   mode3 = 1'b0;
   int   tests = 0, fails = 0;

   spi_target_if bus ();

   spi_target #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .interrupt   (interrupt),
      .spi_sck     (spi_sck),
      .spi_cs_n    (spi_cs_n),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic half_period();
      repeat (HALF) @(negedge clk);
   endtask

   task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.select = 1'b1; bus.wr = 4'hF; bus.addr = a; bus.data_in = d;
      @(negedge clk);
      bus.select = 1'b0; bus.wr = 4'h0;
   endtask

   task automatic cpu_rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.select = 1'b1; bus.rd = 1'b1; bus.addr = a;
      #1 d = bus.data_out;
      @(negedge clk);
      bus.select = 1'b0; bus.rd = 1'b0;
   endtask

   // Look at a register without a read strobe (no side effects).
   task automatic peek(input logic [1:0] a, output logic [31:0] d);
      bus.addr = a;
      #1 d = bus.data_out;
   endtask

   task automatic set_cs(input logic v);
      @(negedge clk);
      spi_cs_n = v;
      half_period();
      half_period();
   endtask

   // Sends tx[7] .. tx[8-n]; returns MISO bits sampled just before each rising edge.
   task automatic host_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = '0;
      for (int i = 0; i < n; i++) begin
         if (mode3) spi_sck = 1'b0;
         spi_mosi = tx[7-i];
         half_period();
         rx[7-i] = spi_miso;
         spi_sck = 1'b1;
         half_period();
         if (!mode3) spi_sck = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      @(negedge clk);
      peek(REG_STATUS, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_status: got %h want %h", d, 32'h0); end
      peek(REG_FILL, d);
      tests++; if (d !== 32'hFF) begin fails++; $display("FAIL reset_fill: got %h want %h", d, 32'hFF); end
      peek(REG_CTRL, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_ctrl: got %h want %h", d, 32'h0); end
      peek(REG_DATA, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want %h", d, 32'h0); end
      tests++; if ({spi_miso, spi_miso_oe, interrupt} !== 3'b100)
         begin fails++; $display("FAIL reset_pins: got miso/oe/irq %b want 100", {spi_miso, spi_miso_oe, interrupt}); end
   endtask

   task automatic test_basic();
      logic [31:0] d;
      logic [7:0]  rx;
      cpu_wr(REG_CTRL, 32'h3);
      cpu_wr(REG_DATA, 32'hA5);
      @(negedge clk); peek(REG_STATUS, d);
      tests++; if (d !== 32'h04) begin fails++; $display("FAIL basic_txfull: got %h want %h", d, 32'h04); end
      set_cs(1'b0);
      tests++; if (spi_miso_oe !== 1'b1) begin fails++; $display("FAIL basic_oe: got %b want 1", spi_miso_oe); end
      host_bits(8'h3C, 8, rx);
      set_cs(1'b1);
      tests++; if (rx !== 8'hA5) begin fails++; $display("FAIL basic_miso: got %h want %h", rx, 8'hA5); end
      tests++; if (interrupt !== 1'b1) begin fails++; $display("FAIL basic_rx_irq: got %b want 1", interrupt); end
      @(negedge clk); peek(REG_STATUS, d);
      tests++; if (d !== 32'h51) begin fails++; $display("FAIL basic_status: got %h want %h", d, 32'h51); end
      cpu_rd(REG_DATA, d);
      tests++; if (d !== 32'h13C) begin fails++; $display("FAIL basic_data: got %h want %h", d, 32'h13C); end
      cpu_rd(REG_DATA, d);
      tests++; if (d[8] !== 1'b0) begin fails++; $display("FAIL basic_empty_read: got bit8 %b want 0", d[8]); end
      @(negedge clk);
      tests++; if (interrupt !== 1'b0) begin fails++; $display("FAIL basic_irq_clear: got %b want 0", interrupt); end
      cpu_wr(REG_STATUS, 32'h70);
   endtask

   task automatic test_underrun();
      logic [31:0] d;
      logic [7:0]  rx0, rx1;
      cpu_wr(REG_CTRL, 32'h1);
      cpu_wr(REG_FILL, 32'h5A);
      set_cs(1'b0);
      host_bits(8'h11, 8, rx0);
      host_bits(8'h22, 8, rx1);
      set_cs(1'b1);
      tests++; if ({rx0, rx1} !== 16'h5A5A) begin fails++; $display("FAIL underrun_fill: got %h want %h", {rx0, rx1}, 16'h5A5A); end
      @(negedge clk); peek(REG_STATUS, d);
      tests++; if (d !== 32'h51) begin fails++; $display("FAIL underrun_set: got %h want %h", d, 32'h51); end
      cpu_wr(REG_STATUS, 32'h10);
      @(negedge clk); peek(REG_STATUS, d);
      tests++; if (d !== 32'h41) begin fails++; $display("FAIL underrun_w1c: got %h want %h", d, 32'h41); end
      cpu_rd(REG_DATA, d);
      tests++; if (d !== 32'h111) begin fails++; $display("FAIL underrun_rx0: got %h want %h", d, 32'h111); end
      cpu_rd(REG_DATA, d);
      tests++; if (d !== 32'h122) begin fails++; $display("FAIL underrun_rx1: got %h want %h", d, 32'h122); end
      cpu_wr(REG_STATUS, 32'h70);
   endtask

   task automatic test_overrun();
      logic [31:0] d;
      logic [7:0]  rx;
      set_cs(1'b0);
      for (int i = 1; i <= 5; i++) host_bits(8'(i), 8, rx);
      set_cs(1'b1);
      @(negedge clk); peek(REG_STATUS, d);
      tests++; if (d !== 32'h73) begin fails++; $display("FAIL overrun_status: got %h want %h", d, 32'h73); end
      for (int i = 1; i <= 4; i++) begin
         cpu_rd(REG_DATA, d);
         tests++; if (d !== 32'h100 + 32'(i)) begin fails++; $display("FAIL overrun_keep%0d: got %h want %h", i, d, 32'h100 + 32'(i)); end
      end
      cpu_rd(REG_DATA, d);
      tests++; if (d[8] !== 1'b0) begin fails++; $display("FAIL overrun_drained: got bit8 %b want 0", d[8]); end
      cpu_wr(REG_STATUS, 32'h70);
      // Pop lands in the very cycle the fifth byte is pushed.
      set_cs(1'b0);
      for (int i = 1; i <= 4; i++) host_bits(8'(i), 8, rx);
      host_bits(8'h05, 7, rx);
      spi_mosi = 1'b1;
      half_period();
      spi_sck = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.select = 1'b1; bus.rd = 1'b1; bus.addr = REG_DATA;
      #1 d = bus.data_out;
      tests++; if (d !== 32'h101) begin fails++; $display("FAIL coinc_pop: got %h want %h", d, 32'h101); end
      @(negedge clk);
      bus.select = 1'b0; bus.rd = 1'b0;
      half_period();
      spi_sck = 1'b0;
      set_cs(1'b1);
      @(negedge clk); peek(REG_STATUS, d);
      tests++; if (d !== 32'h53) begin fails++; $display("FAIL coinc_status: got %h want %h", d, 32'h53); end
      for (int i = 2; i <= 5; i++) begin
         cpu_rd(REG_DATA, d);
         tests++; if (d !== 32'h100 + 32'(i)) begin fails++; $display("FAIL coinc_rx%0d: got %h want %h", i, d, 32'h100 + 32'(i)); end
      end
      cpu_wr(REG_STATUS, 32'h70);
   endtask

   task automatic test_eof();
      logic [31:0] d;
      logic [7:0]  rx;
      bit          seen;
      int          k;
      cpu_wr(REG_CTRL, 32'h5);
      set_cs(1'b0);
      host_bits(8'hFF, 5, rx);
      @(negedge clk);
      spi_cs_n = 1'b1;
      bus.addr = REG_STATUS;
      seen = 1'b0; k = 0;
      while (!seen && k < 20) begin
         @(negedge clk); #1;
         seen = bus.data_out[ST_EOF];
         k++;
      end
      tests++; if (!seen) begin fails++; $display("FAIL eof_set: got eof 0 want 1 within 20 cycles"); end
      tests++; if (interrupt !== 1'b0) begin fails++; $display("FAIL eof_irq_latency: got %b want 0", interrupt); end
      @(negedge clk);
      tests++; if (interrupt !== 1'b1) begin fails++; $display("FAIL eof_irq: got %b want 1", interrupt); end
      peek(REG_DATA, d);
      tests++; if (d[8] !== 1'b0) begin fails++; $display("FAIL eof_no_push: got bit8 %b want 0", d[8]); end
      cpu_wr(REG_STATUS, 32'h70);
      @(negedge clk); @(negedge clk);
      tests++; if (interrupt !== 1'b0) begin fails++; $display("FAIL eof_irq_clear: got %b want 0", interrupt); end
      half_period();
      cpu_wr(REG_DATA, 32'h1E);
      set_cs(1'b0);
      host_bits(8'hC5, 8, rx);
      set_cs(1'b1);
      tests++; if (rx !== 8'h1E) begin fails++; $display("FAIL eof_realign_miso: got %h want %h", rx, 8'h1E); end
      cpu_rd(REG_DATA, d);
      tests++; if (d !== 32'h1C5) begin fails++; $display("FAIL eof_realign_rx: got %h want %h", d, 32'h1C5); end
      cpu_wr(REG_STATUS, 32'h70);
   endtask

   task automatic test_mode3();
      logic [31:0] d;
      logic [7:0]  rx;
      cpu_wr(REG_CTRL, 32'h1);
      mode3 = 1'b1;
      @(negedge clk); spi_sck = 1'b1;
      half_period(); half_period();
      cpu_wr(REG_DATA, 32'h37);
      set_cs(1'b0);
      host_bits(8'h81, 8, rx);
      set_cs(1'b1);
      tests++; if (rx !== 8'h37) begin fails++; $display("FAIL mode3_miso: got %h want %h", rx, 8'h37); end
      cpu_rd(REG_DATA, d);
      tests++; if (d !== 32'h181) begin fails++; $display("FAIL mode3_rx: got %h want %h", d, 32'h181); end
      cpu_wr(REG_STATUS, 32'h70);
      set_cs(1'b0);
      host_bits(8'hF0, 3, rx);
      cpu_wr(REG_CTRL, 32'h0);
      repeat (3) @(negedge clk);
      tests++; if (spi_miso_oe !== 1'b0) begin fails++; $display("FAIL en0_oe: got %b want 0", spi_miso_oe); end
      host_bits(8'h80, 5, rx);
      set_cs(1'b1);
      peek(REG_STATUS, d);
      tests++; if ((d & 32'h41) !== 32'h0) begin fails++; $display("FAIL en0_no_push: got status %h want eof/rxne clear", d); end
      mode3 = 1'b0;
      @(negedge clk); spi_sck = 1'b0;
      half_period();
      cpu_wr(REG_STATUS, 32'h70);
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      logic [7:0]  rx;
      cpu_wr(REG_CTRL, 32'h1);
      cpu_wr(REG_FILL, 32'h33);
      set_cs(1'b0);
      host_bits(8'hFF, 4, rx);
      @(negedge clk); reset = 1'b1;
      repeat (2) @(negedge clk);
      peek(REG_STATUS, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL rstmid_status: got %h want %h", d, 32'h0); end
      peek(REG_FILL, d);
      tests++; if (d !== 32'hFF) begin fails++; $display("FAIL rstmid_fill: got %h want %h", d, 32'hFF); end
      tests++; if (spi_miso_oe !== 1'b0) begin fails++; $display("FAIL rstmid_oe: got %b want 0", spi_miso_oe); end
      reset = 1'b0; spi_cs_n = 1'b1;
      half_period(); half_period();
      cpu_wr(REG_CTRL, 32'h1);
      cpu_wr(REG_DATA, 32'h96);
      set_cs(1'b0);
      host_bits(8'h4B, 8, rx);
      set_cs(1'b1);
      tests++; if (rx !== 8'h96) begin fails++; $display("FAIL rstmid_miso: got %h want %h", rx, 8'h96); end
      cpu_rd(REG_DATA, d);
      tests++; if (d !== 32'h14B) begin fails++; $display("FAIL rstmid_rx: got %h want %h", d, 32'h14B); end
   endtask

   initial begin
      bus.select = 1'b0; bus.wr = 4'h0; bus.rd = 1'b0;
      bus.addr = 2'd0; bus.data_in = 32'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_basic();
      test_underrun();
      test_overrun();
      test_eof();
      test_mode3();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
